backlight_scheduler: RTL and testbench
======================================

Name: backlight_scheduler

Overview:
- Sequences the watch backlight LED between three sources: the backlight button, the alarm flash request, and a timed fade-out.
- Sits between the button/alarm logic and the LED driver pin, in place of a plain on/off timer.
- Owns the hold timer, the fade-out brightness ramp (PWM), and the alarm flash pattern.
- Alarm has priority over the button.

Parameters:
- TICKS_PER_SEC, 50000: clocks per second.
- ON_SECONDS, 3: full-brightness hold time after the last button press.
- FADE_TICKS, 6256: clocks each fade level is held. Must be a multiple of 8.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- btn_backlight  input  1  backlight button level, already debounced and synchronous to clk.
- alarm_active  input  1  level; high while the alarm is sounding.
- light  output  1  LED drive, registered.
- bl_state  output  2  current state: OFF=00, ON=01, FADE=10, FLASH=11.
- bl_level  output  3  current duty level, 0..7.

Behaviour:
- Reset is asynchronous and active-high. While reset is high:
  - bl_state=OFF, light=0, bl_level=0.
  - Hold timer, fade counter, flash counter and PWM counter all = 0.
  - btn_q = 1, so a button held through reset release is not a press.
- Press detection:
  - press = btn_backlight & ~btn_q.
  - btn_q registers btn_backlight every clock.
- Latency: all outputs are registered. An input sampled at edge N is reflected on light, bl_state and bl_level right after edge N.
- PWM:
  - 3-bit pwm_cnt free-runs 0..7 and wraps.
  - In FADE: light = (pwm_cnt < bl_level).
  - In ON: light=1, bl_level=7. In OFF: light=0, bl_level=0.
- Hold timer load value: ON_SECONDS*TICKS_PER_SEC-1.
- State OFF:
  - alarm_active=1 → FLASH. Flash counter=0.
  - else press → ON. Hold timer loaded.
- State ON:
  - Hold timer decrements every clock.
  - alarm_active=1 → FLASH. Alarm has priority over a simultaneous press.
  - press → stay ON, timer reloaded (retrigger).
  - Timer == 0 → FADE. bl_level=6, fade counter loaded with FADE_TICKS-1.
  - light is therefore high for exactly ON_SECONDS*TICKS_PER_SEC clocks after the last press, then FADE begins.
- State FADE:
  - Fade counter decrements every clock.
  - At 0: if bl_level>1, bl_level decrements and the counter reloads; if bl_level==1 → OFF.
  - Levels run 6..1. Total fade time = 6*FADE_TICKS clocks.
  - press → ON, timer reloaded.
  - alarm_active=1 → FLASH. Priority over press.
- State FLASH:
  - Flash counter counts 0..TICKS_PER_SEC-1 and wraps.
  - light=1 while counter < TICKS_PER_SEC/2, else 0. bl_level=7.
  - Presses are ignored.
  - alarm_active falls → ON, hold timer loaded, so the light stays on ON_SECONDS after the alarm is dismissed.
- Simultaneous press and timer expiry in ON: press wins, stay ON and reload.
- Simultaneous press and last fade step in FADE: press wins → ON.
- Reset mid-operation: immediate return to OFF, light=0 asynchronously.
- No counter may underflow. Timers only decrement in their owning state.

Test Plan:
All scenarios use TICKS_PER_SEC=10, ON_SECONDS=3, FADE_TICKS=16.
1. Reset high for 3 clocks with btn_backlight=1, then release reset and keep btn high → light=0, bl_state=00 throughout (no spurious press).
2. Single 1-clock press at edge N → light=1 and bl_state=01 from edge N through edge N+29. bl_state=10 after edge N+30. bl_state=00 and light=0 after edge N+30+96.
3. Second press at N+20 during ON → light stays 1 until N+49, FADE at N+50.
4. During FADE at bl_level=3, count light-high clocks over one 8-clock PWM window → exactly 3. A press then → bl_state=01, light=1 next clock.
5. alarm_active=1 from OFF for 25 clocks, with presses injected → light pattern 5 high / 5 low repeating, starting high, bl_state=11. On alarm fall → ON for 30 clocks.
6. Assert reset during FLASH and during FADE → light=0 and bl_state=00 immediately (before the next clk edge). Normal press behaviour after release.

Source files
------------

// File: rtl/backlight_scheduler.sv
// Watch backlight sequencer: button hold timer, PWM fade-out ramp and
// alarm flash pattern. Alarm requests take priority over the button.
module backlight_scheduler #(
  parameter int unsigned TICKS_PER_SEC = 50000,
  parameter int unsigned ON_SECONDS    = 3,
  parameter int unsigned FADE_TICKS    = 6256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_backlight,
  input  logic       alarm_active,
  output logic       light,
  output logic [1:0] bl_state,
  output logic [2:0] bl_level
);

  localparam int unsigned HOLD_TICKS = ON_SECONDS * TICKS_PER_SEC;
  localparam int unsigned TMR_W      = (HOLD_TICKS > 1)    ? $clog2(HOLD_TICKS)    : 1;
  localparam int unsigned FADE_W     = (FADE_TICKS > 1)    ? $clog2(FADE_TICKS)    : 1;
  localparam int unsigned FLASH_W    = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  localparam logic [TMR_W-1:0]   HOLD_LOAD  = TMR_W'(HOLD_TICKS - 1);
  localparam logic [FADE_W-1:0]  FADE_LOAD  = FADE_W'(FADE_TICKS - 1);
  localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(TICKS_PER_SEC - 1);
  localparam logic [FLASH_W-1:0] FLASH_HALF = FLASH_W'(TICKS_PER_SEC / 2);

  localparam logic [1:0] S_OFF   = 2'b00;
  localparam logic [1:0] S_ON    = 2'b01;
  localparam logic [1:0] S_FADE  = 2'b10;
  localparam logic [1:0] S_FLASH = 2'b11;

  logic [1:0]         r_state;
  logic [TMR_W-1:0]   r_tmr;
  logic [FADE_W-1:0]  r_fade;
  logic [FLASH_W-1:0] r_flash;
  logic [2:0]         r_pwm;
  logic [2:0]         r_level;
  logic               r_light;
  logic               r_btn_q;

  logic [1:0]         w_state_nx;
  logic [TMR_W-1:0]   w_tmr_nx;
  logic [FADE_W-1:0]  w_fade_nx;
  logic [FLASH_W-1:0] w_flash_nx;
  logic [2:0]         w_pwm_nx;
  logic [2:0]         w_level_nx;
  logic               w_light_nx;
  logic               w_press;

  assign w_press = btn_backlight & ~r_btn_q;

  // Next-state, counter and output decode; light is derived from next values
  // so every output reflects the inputs sampled at the same edge.
  always_comb begin
    w_state_nx = r_state;
    w_tmr_nx   = r_tmr;
    w_fade_nx  = r_fade;
    w_flash_nx = r_flash;
    w_level_nx = r_level;
    w_pwm_nx   = r_pwm + 3'd1;
    w_light_nx = 1'b0;

    case (r_state)
      S_OFF: begin
        if (alarm_active) begin
          w_state_nx = S_FLASH;
          w_flash_nx = '0;
          w_level_nx = 3'd7;
        end else if (w_press) begin
          w_state_nx = S_ON;
          w_tmr_nx   = HOLD_LOAD;
          w_level_nx = 3'd7;
        end
      end
      S_ON: begin
        if (alarm_active) begin
          w_state_nx = S_FLASH;
          w_flash_nx = '0;
          w_level_nx = 3'd7;
        end else if (w_press) begin
          w_tmr_nx   = HOLD_LOAD;
        end else if (r_tmr == '0) begin
          w_state_nx = S_FADE;
          w_level_nx = 3'd6;
          w_fade_nx  = FADE_LOAD;
        end else begin
          w_tmr_nx   = r_tmr - TMR_W'(1);
        end
      end
      S_FADE: begin
        if (alarm_active) begin
          w_state_nx = S_FLASH;
          w_flash_nx = '0;
          w_level_nx = 3'd7;
        end else if (w_press) begin
          w_state_nx = S_ON;
          w_tmr_nx   = HOLD_LOAD;
          w_level_nx = 3'd7;
        end else if (r_fade == '0) begin
          if (r_level > 3'd1) begin
            w_level_nx = r_level - 3'd1;
            w_fade_nx  = FADE_LOAD;
          end else begin
            w_state_nx = S_OFF;
            w_level_nx = 3'd0;
          end
        end else begin
          w_fade_nx  = r_fade - FADE_W'(1);
        end
      end
      default: begin
        w_level_nx = 3'd7;
        if (!alarm_active) begin
          w_state_nx = S_ON;
          w_tmr_nx   = HOLD_LOAD;
        end else if (r_flash == FLASH_LAST) begin
          w_flash_nx = '0;
        end else begin
          w_flash_nx = r_flash + FLASH_W'(1);
        end
      end
    endcase

    case (w_state_nx)
      S_ON:    w_light_nx = 1'b1;
      S_FADE:  w_light_nx = (w_pwm_nx < w_level_nx);
      S_FLASH: w_light_nx = (w_flash_nx < FLASH_HALF);
      default: w_light_nx = 1'b0;
    endcase
  end

  // State, counters and registered outputs; reset forces the LED off at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_OFF;
      r_tmr   <= '0;
      r_fade  <= '0;
      r_flash <= '0;
      r_pwm   <= 3'd0;
      r_level <= 3'd0;
      r_light <= 1'b0;
      r_btn_q <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_tmr   <= w_tmr_nx;
      r_fade  <= w_fade_nx;
      r_flash <= w_flash_nx;
      r_pwm   <= w_pwm_nx;
      r_level <= w_level_nx;
      r_light <= w_light_nx;
      r_btn_q <= btn_backlight;
    end
  end

  assign light    = r_light;
  assign bl_state = r_state;
  assign bl_level = r_level;

endmodule

// File: tb/tb_backlight_scheduler.sv
// Directed bench for backlight_scheduler with small timing parameters.
module tb_backlight_scheduler;

  localparam int unsigned TPS = 10;
  localparam int unsigned ONS = 3;
  localparam int unsigned FT  = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_backlight;
  logic       alarm_active;
  logic       light;
  logic [1:0] bl_state;
  logic [2:0] bl_level;

  int n_cmp = 0;
  int n_bad = 0;
  int hi;

  backlight_scheduler #(
    .TICKS_PER_SEC(TPS),
    .ON_SECONDS   (ONS),
    .FADE_TICKS   (FT)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .btn_backlight(btn_backlight),
    .alarm_active (alarm_active),
    .light        (light),
    .bl_state     (bl_state),
    .bl_level     (bl_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    btn_backlight = 1'b1;
    alarm_active  = 1'b0;
    #2;
    check("rst_out", {light, bl_state, bl_level}, 6'b0_00_000);

    // 1: button held through reset release is not a press
    tick(3);
    check("rst_hold", {light, bl_state}, 3'b000);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check("no_spurious", {light, bl_state}, 3'b000);
    end

    // 2: single press, 30-clock hold, 6-level fade
    btn_backlight = 1'b0;
    tick(2);
    check("off_idle", {light, bl_state, bl_level}, 6'b0_00_000);
    btn_backlight = 1'b1;
    tick(1);
    btn_backlight = 1'b0;
    check("press_on", {light, bl_state, bl_level}, 6'b1_01_111);
    for (int k = 1; k < 30; k++) begin
      tick(1);
      check("hold_on", {light, bl_state}, 3'b101);
    end
    tick(1);
    check("fade_entry", {bl_state, bl_level}, 5'b10_110);
    for (int lv = 6; lv >= 1; lv--) begin
      hi = 0;
      for (int i = 0; i < 16; i++) begin
        if (i == 0 || i == 15) check("fade_level", {bl_state, bl_level}, {2'b10, 3'(lv)});
        hi += int'(light);
        if (!(lv == 1 && i == 15)) tick(1);
      end
      check("fade_duty", hi, 2 * lv);
    end
    // press on the final fade step beats the return to OFF
    btn_backlight = 1'b1;
    tick(1);
    btn_backlight = 1'b0;
    check("press_last_fade", {light, bl_state}, 3'b101);
    // press on hold-timer expiry beats entering FADE
    tick(29);
    check("hold_end", {light, bl_state}, 3'b101);
    btn_backlight = 1'b1;
    tick(1);
    btn_backlight = 1'b0;
    check("press_expiry", {light, bl_state}, 3'b101);
    tick(29);
    check("reload_hold", {light, bl_state}, 3'b101);
    tick(1);
    check("reload_fade", {bl_state, bl_level}, 5'b10_110);
    tick(95);
    check("fade_last", {bl_state, bl_level}, 5'b10_001);
    tick(1);
    check("fade_done", {light, bl_state, bl_level}, 6'b0_00_000);

    // 3: retrigger at N+20 extends hold to N+49
    btn_backlight = 1'b1;
    tick(1);
    btn_backlight = 1'b0;
    tick(19);
    btn_backlight = 1'b1;
    tick(1);
    btn_backlight = 1'b0;
    tick(29);
    check("retrig_hold", {light, bl_state}, 3'b101);
    tick(1);
    check("retrig_fade", bl_state, 2'b10);

    // 4: duty at level 3 over one PWM window, then press back to ON
    tick(48);
    check("lvl3", bl_level, 3'd3);
    hi = int'(light);
    for (int i = 1; i < 8; i++) begin
      tick(1);
      hi += int'(light);
    end
    check("lvl3_window", hi, 3);
    btn_backlight = 1'b1;
    tick(1);
    btn_backlight = 1'b0;
    check("fade_press", {light, bl_state, bl_level}, 6'b1_01_111);
    tick(30);
    check("refade", bl_state, 2'b10);
    tick(96);
    check("reoff", {light, bl_state}, 3'b000);

    // 5: alarm flash 5 high / 5 low, presses ignored, then 30-clock hold
    alarm_active = 1'b1;
    tick(1);
    for (int k = 0; k < 25; k++) begin
      check("flash", {light, bl_state}, {((k % 10) < 5) ? 1'b1 : 1'b0, 2'b11});
      if (k == 0) check("flash_level", bl_level, 3'd7);
      btn_backlight = ((k % 3) == 0);
      if (k < 24) tick(1);
    end
    alarm_active  = 1'b0;
    btn_backlight = 1'b0;
    tick(1);
    check("alarm_fall_on", {light, bl_state, bl_level}, 6'b1_01_111);
    tick(29);
    check("alarm_hold", {light, bl_state}, 3'b101);
    tick(1);
    check("alarm_fade", bl_state, 2'b10);

    // 6: asynchronous reset in FADE and in FLASH
    #2;
    reset = 1'b1;
    #1;
    check("rst_in_fade", {light, bl_state, bl_level}, 6'b0_00_000);
    tick(2);
    reset = 1'b0;
    tick(1);
    check("post_rst_off", {light, bl_state}, 3'b000);
    alarm_active = 1'b1;
    tick(3);
    check("flash_pre_rst", {light, bl_state}, 3'b111);
    #2;
    reset = 1'b1;
    #1;
    check("rst_in_flash", {light, bl_state, bl_level}, 6'b0_00_000);
    alarm_active = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(1);
    btn_backlight = 1'b1;
    tick(1);
    btn_backlight = 1'b0;
    check("post_rst_press", {light, bl_state, bl_level}, 6'b1_01_111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
